// File: rtl/adder_tree_sched_if.sv
// Handshake bundle for adder_tree_sched: two job requesters and one result port.
interface adder_tree_sched_if #(
   parameter int ADDER_WIDTH = 17,
   parameter int NUM_OPS = 8
);
   localparam int SUM_WIDTH = ADDER_WIDTH + $clog2(NUM_OPS);

   logic                           req0_valid;
   logic [ADDER_WIDTH*NUM_OPS-1:0] req0_data;
   logic                           req0_ready;
   logic                           req1_valid;
   logic [ADDER_WIDTH*NUM_OPS-1:0] req1_data;
   logic                           req1_ready;
   logic                           res_valid;
   logic                           res_ready;
   logic [SUM_WIDTH-1:0]           res_sum;
   logic                           res_id;
   logic                           busy;

   modport master (
      output req0_valid, req0_data, req1_valid, req1_data, res_ready,
      input  req0_ready, req1_ready, res_valid, res_sum, res_id, busy
   );

   modport slave (
      input  req0_valid, req0_data, req1_valid, req1_data, res_ready,
      output req0_ready, req1_ready, res_valid, res_sum, res_id, busy
   );
endinterface

// File: rtl/adder_tree_sched.sv
// Two-requester round-robin job scheduler sharing one accumulating adder.
// ADDER_TREE_SCHED_PAIR_EN: add two operands per ACC cycle instead of one.
module adder_tree_sched #(
   parameter int ADDER_WIDTH = 17,
   parameter int NUM_OPS = 8
) (
   input logic clk,
   input logic rst_n,
   adder_tree_sched_if.slave bus
);
   localparam int SUM_WIDTH = ADDER_WIDTH + $clog2(NUM_OPS);
   localparam int IW = $clog2(NUM_OPS);
`ifdef ADDER_TREE_SCHED_PAIR_EN
   localparam int STEPS = NUM_OPS / 2;
`else
   localparam int STEPS = NUM_OPS;
`endif
   localparam logic [IW-1:0] LAST = IW'(STEPS - 1);

   typedef enum logic [1:0] {
      IDLE,
      ACC,
      OUT
   } state_t;

   state_t                         state_q;
   state_t                         state_d;
   logic                           ptr_q;
   logic                           id_q;
   logic [IW-1:0]                  cnt_q;
   logic [SUM_WIDTH-1:0]           acc_q;
   logic [ADDER_WIDTH-1:0]         ops_q [NUM_OPS];
   logic                           grant0;
   logic                           grant1;
   logic                           accept;
   logic [ADDER_WIDTH*NUM_OPS-1:0] sel_data;
   logic [SUM_WIDTH-1:0]           addend;

   // Readies are gated by rst_n so nothing is granted while reset is held.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (rst_n && state_q == IDLE) begin
         if (bus.req0_valid && bus.req1_valid) begin
            grant0 = !ptr_q;
            grant1 = ptr_q;
         end else begin
            grant0 = bus.req0_valid;
            grant1 = bus.req1_valid;
         end
      end
   end

   assign accept   = grant0 | grant1;
   assign sel_data = grant1 ? bus.req1_data : bus.req0_data;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (accept) state_d = ACC;
         ACC:  if (cnt_q == LAST) state_d = OUT;
         OUT:  if (bus.res_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

`ifdef ADDER_TREE_SCHED_PAIR_EN
   logic [IW-1:0]        idx_lo;
   logic [IW-1:0]        idx_hi;
   logic [ADDER_WIDTH:0] pair_sum;

   always_comb begin
      idx_lo   = cnt_q << 1;
      idx_hi   = idx_lo | IW'(1);
      pair_sum = {1'b0, ops_q[idx_lo]} + {1'b0, ops_q[idx_hi]};
      addend   = SUM_WIDTH'(pair_sum);
   end
`else
   always_comb begin
      addend = SUM_WIDTH'(ops_q[cnt_q]);
   end
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= 1'b0;
         id_q    <= 1'b0;
         cnt_q   <= '0;
         acc_q   <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            ptr_q <= !grant1;
            id_q  <= grant1;
            cnt_q <= '0;
            acc_q <= '0;
         end else if (state_q == ACC) begin
            acc_q <= acc_q + addend;
            cnt_q <= cnt_q + IW'(1);
         end
      end
   end

   // Operand store needs no reset: it is only read after a capture.
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int k = 0; k < NUM_OPS; k++) begin
            ops_q[k] <= sel_data[k*ADDER_WIDTH +: ADDER_WIDTH];
         end
      end
   end

   assign bus.req0_ready = grant0;
   assign bus.req1_ready = grant1;
   assign bus.res_valid  = (state_q == OUT);
   assign bus.res_sum    = acc_q;
   assign bus.res_id     = id_q;
   assign bus.busy       = (state_q != IDLE);
endmodule

// File: doc/adder_tree_sched.md
ADDER_TREE_SCHED -- requirements
Module: adder_tree_sched

Interface
REQ-001 SHALL have parameter ADDER_WIDTH, default 17, meaning unsigned operand width in bits.
REQ-002 SHALL have parameter NUM_OPS, default 8, meaning operands per job; power of two, at least 2.
REQ-003 SHALL derive SUM_WIDTH = ADDER_WIDTH + log2(NUM_OPS), default 20.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset; synchronous, active-low.
REQ-006 req0_valid  input  1  requester 0 has a job.
REQ-007 req0_data  input  ADDER_WIDTH*NUM_OPS  requester 0 packed operands; operand k at bits [k*ADDER_WIDTH +: ADDER_WIDTH].
REQ-008 req0_ready  output  1  requester 0 job accepted this cycle.
REQ-009 req1_valid, req1_data, req1_ready: same as REQ-006..008 for requester 1.
REQ-010 res_valid  output  1  result available.
REQ-011 res_ready  input  1  consumer accepts result.
REQ-012 res_sum  output  SUM_WIDTH  sum of the job's operands.
REQ-013 res_id  output  1  requester that issued the job.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 SHALL implement the FSM IDLE -> ACC -> OUT -> IDLE, sharing one adder datapath between both requesters.
REQ-016 In IDLE, SHALL assert the ready of exactly one valid requester, chosen combinationally; no ready while both valids are low; no ready outside IDLE.
REQ-017 Arbitration SHALL be round-robin: the priority pointer names the favoured requester; on simultaneous valids, the favoured requester wins; after any grant, the pointer moves to the other requester.
REQ-018 On an accept edge (valid && ready), SHALL capture operands and the requester id, clear the accumulator and the operand counter, and enter ACC.
REQ-019 In ACC, SHALL add one operand per cycle in index order 0..NUM_OPS-1; after the NUM_OPS-th add, SHALL enter OUT.
REQ-020 res_valid SHALL rise exactly NUM_OPS cycles after the accept edge (8 at default).
REQ-021 Accumulation SHALL be unsigned and zero-extended to SUM_WIDTH; it cannot overflow.
REQ-022 In OUT, res_valid, res_sum and res_id SHALL hold stable until res_ready is sampled high; the FSM then returns to IDLE.
REQ-023 After a result handshake, SHALL spend at least one IDLE cycle before the next accept; maximum throughput is one job per NUM_OPS+2 cycles.
REQ-024 Input valid/data changes outside the accept edge SHALL NOT affect an in-flight job.

Reset
REQ-025 While rst_n is low at a clock edge, SHALL go to IDLE with res_valid=0, res_sum=0, res_id=0, busy=0, pointer=requester 0, accumulator=0 and counter=0.
REQ-026 Reset during ACC or OUT SHALL discard the job with no result produced; the requester is not re-accepted unless it re-asserts valid.
REQ-027 req0_ready and req1_ready SHALL be low while rst_n is low.

Configuration
REQ-028 Macro ADDER_TREE_SCHED_PAIR_EN: when defined, ACC SHALL add two operands per cycle (2k and 2k+1 through a 2-input adder of ADDER_WIDTH+1 bits), complete in NUM_OPS/2 cycles, and res_valid SHALL rise NUM_OPS/2 cycles after accept.
REQ-029 When the macro is not defined, SHALL behave per REQ-019/020 (one operand per cycle); results SHALL be identical in both modes.

Verification
REQ-030 req0 only, 8 operands of 1 -> res_valid 8 cycles after accept, res_sum=8, res_id=0, req1_ready never high.
REQ-031 req1 only, 8 operands of 0x1FFFF -> res_sum=0xFFFF8, res_id=1.
REQ-032 Both valid continuously from reset, operands 1..8 on req0 and 10..80 on req1 -> results in order: 36 (id 0), 360 (id 1), 36 (id 0); strict alternation.
REQ-033 res_ready low for 5 cycles in OUT -> res_sum and res_id stable, busy=1, both ready signals low; one cycle after res_ready rises, FSM is in IDLE.
REQ-034 rst_n low for 1 cycle at the 4th ACC cycle -> no res_valid; pointer=0; the next job accepted with operands of 2 yields 16.
REQ-035 With ADDER_TREE_SCHED_PAIR_EN defined, the REQ-030 stimulus -> res_valid 4 cycles after accept, res_sum=8.
